// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a big-endian word-addressed data memory.
// Handles byte/halfword/word loads with extension and byte/halfword stores via read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t      state;
  size_t       size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [15:0] wlo_q;
  logic        mw_q;
  logic [31:0] wd_q;

  logic        bad_access;
  size_t       size_in;

  assign size_in    = size_t'(size);
  assign bad_access = (size_in == SZ_RSVD) ||
                      ((size_in == SZ_HALF) && addr[0]) ||
                      ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));

  // Write strobe is killed by reset in the same cycle so an interrupted store never lands.
  assign memWrite  = mw_q & ~reset;
  assign writeData = memWrite ? wd_q : '0;

  function automatic logic [31:0] extract(input logic [31:0] w, input size_t sz,
                                          input logic u, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: r = {{24{~u & b[7]}}, b};
      SZ_HALF: r = {{16{~u & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input size_t sz,
                                        input logic [1:0] off, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d;
    end else begin
      r[31:16] = d;
    end
    return r;
  endfunction

  // The merged RMW word is registered at the end of RMW_RD, so RMW_WR drives it straight out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      mw_q    <= 1'b0;
      wd_q    <= '0;
      address <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      off_q   <= '0;
      wlo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req) begin
            size_q <= size_in;
            uns_q  <= uns;
            off_q  <= addr[1:0];
            wlo_q  <= wdata[15:0];
            err    <= 1'b0;
            ready  <= 1'b0;
            if (bad_access) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= RESP;
            end else if (!we) begin
              address <= {addr[31:2], 2'b00};
              state   <= LOAD;
            end else if (size_in == SZ_WORD) begin
              address <= {addr[31:2], 2'b00};
              mw_q    <= 1'b1;
              wd_q    <= wdata;
              state   <= STORE;
            end else begin
              address <= {addr[31:2], 2'b00};
              state   <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata   <= extract(readData, size_q, uns_q, off_q);
          address <= '0;
          done    <= 1'b1;
          state   <= RESP;
        end
        STORE: begin
          mw_q    <= 1'b0;
          wd_q    <= '0;
          address <= '0;
          done    <= 1'b1;
          state   <= RESP;
        end
        RMW_RD: begin
          wd_q  <= merge(readData, size_q, off_q, wlo_q);
          mw_q  <= 1'b1;
          state <= RMW_WR;
        end
        RMW_WR: begin
          mw_q    <= 1'b0;
          wd_q    <= '0;
          address <= '0;
          done    <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          mw_q    <= 1'b0;
          wd_q    <= '0;
          address <= '0;
          done    <= 1'b0;
          ready   <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
